dec_i2c_multi: RTL and testbench

I2C target-side receiver that generalises the single-byte address decoder into a multi-byte write receiver. It synchronises raw SCL/SDA and detects START, repeated START and STOP. It matches the 7-bit address (plus optional general call), drives ACK/NACK through an open-drain enable, and streams up to MAX_BYTES data bytes per transaction to the register bank. It sits between the board-level I2C pads and the local register/command logic.

---
 rtl/dec_i2c_multi.sv | 161 ++++++++++++++++
 tb/tb_dec_i2c_multi.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dec_i2c_multi.sv
// I2C target write receiver: address match, ACK/NACK via sda_oe, up to MAX_BYTES data bytes per transfer.
// Latency: 2 clk from pin edge to detect, 3 clk to registered outputs; no backpressure, pronto only gates stop.
module dec_i2c_multi #(
  parameter int MAX_BYTES   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int GEN_CALL_EN = 0,
  localparam int NB_W       = $clog2(MAX_BYTES + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            scl,
  input  logic            sda,
  input  logic            pronto,
  input  logic [6:0]      endereco_local,
  output logic            sda_oe,
  output logic [6:0]      endereco_recebido,
  output logic            operacao,
  output logic            escrita,
  output logic [7:0]      dado,
  output logic            dado_valido,
  output logic [NB_W-1:0] n_bytes,
  output logic            stop,
  output logic            ocupado
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_DATA, S_ACK_D, S_NACK_D, S_IGNORE
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic scl_s, sda_s, scl_d, sda_d;
  logic rise, fall, start_c, stop_c;

  logic [3:0] bit_cnt;
  logic [6:0] shreg;
  logic [7:0] shift_nxt;
  logic       ack_phase;
  logic       wr_match;

  logic shift_en, byte_done, addr_load, data_load, room, addr_match;
  logic ack_fall, oe_set, oe_clr, esc_set;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda};
      scl_d    <= scl_sync[SYNC_STAGES-1];
      sda_d    <= sda_sync[SYNC_STAGES-1];
    end
  end

  assign scl_s   = scl_sync[SYNC_STAGES-1];
  assign sda_s   = sda_sync[SYNC_STAGES-1];
  assign rise    = scl_s & ~scl_d;
  assign fall    = ~scl_s & scl_d;
  assign start_c = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c  = scl_s & scl_d & ~sda_d & sda_s;

  assign shift_nxt  = {shreg, sda_s};
  assign room       = n_bytes < NB_W'(MAX_BYTES);
  // General call only ever matches a write; a read to 0x00 is ignored.
  assign addr_match = (shift_nxt[7:1] == endereco_local) ||
                      ((GEN_CALL_EN != 0) && (shift_nxt[7:1] == 7'h00) && !shift_nxt[0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_c) begin
      state_nxt = S_ADDR;
    end else if (stop_c) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_ADDR:   if (byte_done) state_nxt = addr_match ? S_ACK_A : S_IGNORE;
        S_ACK_A:  if (ack_fall && ack_phase) state_nxt = operacao ? S_IGNORE : S_DATA;
        S_DATA:   if (byte_done) state_nxt = room ? S_ACK_D : S_NACK_D;
        S_ACK_D:  if (ack_fall && ack_phase) state_nxt = S_DATA;
        S_NACK_D: if (ack_fall && ack_phase) state_nxt = S_IGNORE;
        default:  state_nxt = state;
      endcase
    end
  end

  always_comb begin
    shift_en = 1'b0;
    ack_fall = 1'b0;
    if (!start_c && !stop_c) begin
      shift_en = rise && (state == S_ADDR || state == S_DATA);
      ack_fall = fall && (state == S_ACK_A || state == S_ACK_D || state == S_NACK_D);
    end
    byte_done = shift_en && (bit_cnt == 4'd7);
    addr_load = byte_done && (state == S_ADDR);
    data_load = byte_done && (state == S_DATA) && room;
    // First fall after the byte starts the ACK slot, second fall ends it.
    oe_set    = ack_fall && !ack_phase && (state != S_NACK_D);
    oe_clr    = (ack_fall && ack_phase) || start_c || stop_c;
    esc_set   = ack_fall && !ack_phase && (state == S_ACK_A) && !operacao;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt           <= '0;
      shreg             <= '0;
      ack_phase         <= 1'b0;
      wr_match          <= 1'b0;
      sda_oe            <= 1'b0;
      endereco_recebido <= '0;
      operacao          <= 1'b0;
      escrita           <= 1'b0;
      dado              <= '0;
      dado_valido       <= 1'b0;
      n_bytes           <= '0;
      stop              <= 1'b0;
      ocupado           <= 1'b0;
    end else begin
      escrita     <= esc_set;
      dado_valido <= data_load;
      stop        <= stop_c && wr_match && pronto;

      if (start_c)       bit_cnt <= '0;
      else if (shift_en) bit_cnt <= (bit_cnt == 4'd7) ? 4'd0 : bit_cnt + 4'd1;
      if (shift_en) shreg <= shift_nxt[6:0];

      if (start_c || stop_c) ack_phase <= 1'b0;
      else if (ack_fall)     ack_phase <= ~ack_phase;

      if (oe_clr)      sda_oe <= 1'b0;
      else if (oe_set) sda_oe <= 1'b1;

      if (start_c || stop_c) wr_match <= 1'b0;
      else if (esc_set)      wr_match <= 1'b1;

      if (addr_load) begin
        endereco_recebido <= shift_nxt[7:1];
        operacao          <= shift_nxt[0];
      end

      if (start_c) begin
        n_bytes <= '0;
      end else if (data_load) begin
        n_bytes <= n_bytes + NB_W'(1);
        dado    <= shift_nxt;
      end

      if (start_c)     ocupado <= 1'b1;
      else if (stop_c) ocupado <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dec_i2c_multi.sv
// Bench for dec_i2c_multi: bit-banged I2C master plus a transaction-level expectation model.
module tb_dec_i2c_multi;
  localparam int  MAXB  = 4;
  localparam int  NBW   = $clog2(MAXB + 1);
  localparam time Q     = 40;
  localparam logic [6:0] MY_ADDR = 7'h2A;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           scl = 1'b1;
  logic           sda_m = 1'b1;
  logic           pronto = 1'b1;
  logic [6:0]     endereco_local = MY_ADDR;
  logic           sda_bus;
  logic           sda_oe;
  logic [6:0]     endereco_recebido;
  logic           operacao;
  logic           escrita;
  logic [7:0]     dado;
  logic           dado_valido;
  logic [NBW-1:0] n_bytes;
  logic           stop;
  logic           ocupado;

  assign sda_bus = sda_m & ~sda_oe;

  dec_i2c_multi #(.MAX_BYTES(MAXB), .SYNC_STAGES(2), .GEN_CALL_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .scl(scl), .sda(sda_bus), .pronto(pronto),
    .endereco_local(endereco_local), .sda_oe(sda_oe),
    .endereco_recebido(endereco_recebido), .operacao(operacao), .escrita(escrita),
    .dado(dado), .dado_valido(dado_valido), .n_bytes(n_bytes), .stop(stop),
    .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse/event monitor; tasks only read these, taking deltas per transaction.
  int         esc_cnt = 0, stop_cnt = 0, oe_cnt = 0, dv_n = 0;
  logic [7:0] dv_log [0:1023];
  always @(negedge clk) begin
    if (reset_n) begin
      if (escrita) esc_cnt++;
      if (stop) stop_cnt++;
      if (sda_oe) oe_cnt++;
      if (dado_valido) begin
        dv_log[dv_n] = dado;
        dv_n++;
      end
    end
  end

  logic [7:0] tx_data [0:7];

  task automatic start_cond();
    sda_m = 1'b1; #Q; scl = 1'b1; #Q; sda_m = 1'b0; #Q; scl = 1'b0; #Q;
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
  endtask

  task automatic bit_out(input logic b, output logic seen);
    sda_m = b; #Q; scl = 1'b1; #Q; seen = sda_bus; #Q; scl = 1'b0; #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_out(b[i], s);
    bit_out(1'b1, s);
    ack = ~s;
  endtask

  // Expected behaviour derived from the addressing/byte-count rules only.
  task automatic run_txn(input logic [6:0] addr, input logic rw, input int n,
                         input logic pr, input logic do_stop);
    int   e0, s0, d0, o0, exp_n;
    logic match, wr, ack;
    pronto = pr;
    e0 = esc_cnt; s0 = stop_cnt; d0 = dv_n; o0 = oe_cnt;
    start_cond();
    check("busy_after_start", ocupado, 1);
    check("nbytes_clr_on_start", n_bytes, 0);
    match = (addr == MY_ADDR) || (addr == 7'h00 && !rw);
    wr    = match && !rw;
    send_byte({addr, rw}, ack);
    check("addr_ack", ack, match);
    if (!rw) begin
      for (int i = 0; i < n; i++) begin
        send_byte(tx_data[i], ack);
        check("data_ack", ack, wr && (i < MAXB));
      end
    end
    exp_n = wr ? ((n < MAXB) ? n : MAXB) : 0;
    check("escrita_pulses", esc_cnt - e0, wr);
    check("dado_valido_pulses", dv_n - d0, exp_n);
    for (int k = 0; k < exp_n; k++) check("dado_value", dv_log[d0 + k], tx_data[k]);
    if (exp_n > 0) check("dado_held", dado, tx_data[exp_n - 1]);
    check("n_bytes", n_bytes, exp_n);
    check("endereco_recebido", endereco_recebido, addr);
    check("operacao", operacao, rw);
    if (!match) check("oe_quiet_no_match", oe_cnt - o0, 0);
    if (do_stop) begin
      stop_cond();
      #50;
      check("stop_pulses", stop_cnt - s0, wr && pr);
      check("idle_after_stop", ocupado, 0);
      check("n_bytes_hold", n_bytes, exp_n);
      check("oe_released", sda_oe, 0);
    end else begin
      check("busy_no_stop", ocupado, 1);
    end
  endtask

  task automatic reset_mid_ack();
    logic [7:0] b;
    logic       s;
    b = {MY_ADDR, 1'b0};
    start_cond();
    for (int i = 7; i >= 0; i--) bit_out(b[i], s);
    sda_m = 1'b1; #Q; scl = 1'b1; #Q;
    check("oe_before_reset", sda_oe, 1);
    reset_n = 1'b0;
    #1;
    check("oe_in_reset", sda_oe, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_dado", dado, 0);
    check("rst_n_bytes", n_bytes, 0);
    check("rst_endereco", endereco_recebido, 0);
    check("rst_operacao", operacao, 0);
    check("rst_pulses", {escrita, dado_valido, stop}, 0);
    #20; scl = 1'b0; #Q;
    reset_n = 1'b1; #Q;
    sda_m = 1'b0; #Q; scl = 1'b1; #Q; sda_m = 1'b1; #(2*Q);
  endtask

  initial begin
    int   sel, n;
    logic [6:0] a;
    logic rw, pr, ds;

    #23;
    check("reset_sda_oe", sda_oe, 0);
    check("reset_outputs", {endereco_recebido, operacao, escrita, dado, dado_valido, stop, ocupado}, 0);
    check("reset_n_bytes", n_bytes, 0);
    #20 reset_n = 1'b1;
    #100;

    tx_data[0] = 8'h5A;
    run_txn(MY_ADDR, 1'b0, 1, 1'b1, 1'b1);

    tx_data[0] = 8'h33;
    run_txn(7'h11, 1'b0, 1, 1'b1, 1'b1);

    for (int i = 0; i < 5; i++) tx_data[i] = 8'(i + 1);
    run_txn(MY_ADDR, 1'b0, 5, 1'b1, 1'b1);
    check("dado_after_nack", dado, 8'h04);

    tx_data[0] = 8'h77;
    run_txn(MY_ADDR, 1'b0, 1, 1'b1, 1'b0);
    run_txn(MY_ADDR, 1'b1, 0, 1'b0, 1'b1);

    reset_mid_ack();
    tx_data[0] = 8'hA5;
    run_txn(MY_ADDR, 1'b0, 1, 1'b1, 1'b1);

    tx_data[0] = 8'h06;
    run_txn(7'h00, 1'b0, 1, 1'b1, 1'b1);

    for (int t = 0; t < 24; t++) begin
      sel = $urandom_range(0, 3);
      a   = (sel == 0) ? 7'h00 : (sel == 1) ? 7'($urandom) : MY_ADDR;
      rw  = ($urandom_range(0, 3) == 0);
      n   = $urandom_range(0, 6);
      pr  = 1'($urandom_range(0, 1));
      ds  = (t == 23) || ($urandom_range(0, 4) != 0);
      for (int i = 0; i < 8; i++) tx_data[i] = 8'($urandom);
      run_txn(a, rw, n, pr, ds);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
